// File: rtl/fpu_issue_sched_pkg.sv
// rtl/fpu_issue_sched_pkg.sv - shared types, latencies and helpers for the FPU issue scheduler
// Contents:
//   TAGW              destination-register tag width
//   LAT_*             fixed-unit pipeline depths (issue -> result)
//   MAXLAT            deepest fixed unit; sizes the reservation window
//   SLOTW             width of a reservation slot index (1..MAXLAT)
//   fpu_op_e          request opcode (codes 5-7 are illegal and not enumerated)
//   div_state_e       fdiv tracking state
//   fpu_wb_t          reservation / writeback entry {valid, tag, sel}
//   op_lat()          slot index a fixed op reserves
package fpu_issue_sched_pkg;

  localparam int TAGW     = 5;
  localparam int LAT_ADD  = 2;
  localparam int LAT_MUL  = 2;
  localparam int LAT_FLR  = 1;
  localparam int LAT_ITOF = 1;

  localparam int MAX_AM = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int MAX_FI = (LAT_FLR > LAT_ITOF) ? LAT_FLR : LAT_ITOF;
  localparam int MAXLAT = (MAX_AM > MAX_FI) ? MAX_AM : MAX_FI;
  localparam int SLOTW  = $clog2(MAXLAT + 1);

  typedef enum logic [2:0] {
    OP_FADD  = 3'd0,
    OP_FMUL  = 3'd1,
    OP_FLOOR = 3'd2,
    OP_ITOF  = 3'd3,
    OP_FDIV  = 3'd4
  } fpu_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_KILL = 2'd2
  } div_state_e;

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [2:0]      sel;
  } fpu_wb_t;

  // Only meaningful for the four fixed-latency ops.
  function automatic logic [SLOTW-1:0] op_lat(input logic [2:0] op);
    case (op)
      OP_FADD:  return SLOTW'(LAT_ADD);
      OP_FMUL:  return SLOTW'(LAT_MUL);
      OP_FLOOR: return SLOTW'(LAT_FLR);
      OP_ITOF:  return SLOTW'(LAT_ITOF);
      default:  return SLOTW'(1);
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_sched_if.sv
// rtl/fpu_issue_sched_if.sv - request, unit-control and writeback signals of the FPU issue scheduler
// Signals:
//   req_valid/req_op/req_tag/req_ready  core issue handshake
//   flush                               kill all in-flight ops
//   iss_en                              one-hot fire pulse {itof,floor,fmul,fadd}
//   div_start/div_done                  iterative fdiv start pulse / result-valid pulse
//   wb_valid/wb_tag/wb_sel              FP register writeback port
//   err_illegal                         illegal op consumed
// Modports: master = core/FPU environment side, slave = scheduler side.
interface fpu_issue_sched_if;
  import fpu_issue_sched_pkg::*;

  logic            req_valid;
  logic [2:0]      req_op;
  logic [TAGW-1:0] req_tag;
  logic            req_ready;
  logic            flush;
  logic [3:0]      iss_en;
  logic            div_start;
  logic            div_done;
  logic            wb_valid;
  logic [TAGW-1:0] wb_tag;
  logic [2:0]      wb_sel;
  logic            err_illegal;

  modport master (
    output req_valid, req_op, req_tag, flush, div_done,
    input  req_ready, iss_en, div_start, wb_valid, wb_tag, wb_sel, err_illegal
  );

  modport slave (
    input  req_valid, req_op, req_tag, flush, div_done,
    output req_ready, iss_en, div_start, wb_valid, wb_tag, wb_sel, err_illegal
  );

endinterface

// File: rtl/fpu_issue_sched_wb_slot_pipe.sv
// rtl/fpu_issue_sched_wb_slot_pipe.sv - writeback reservation window, shifts toward slot 1 each cycle
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   clr_i        drop every reservation
//   ins_en_i     reserve a slot this cycle
//   ins_slot_i   slot to reserve (1..MAXLAT), written after the shift
//   ins_data_i   entry to place in that slot
//   head_o       slot 1: the entry that owns the writeback port next cycle
//   vld_o        valid bit of every slot
module fpu_issue_sched_wb_slot_pipe
  import fpu_issue_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             ins_en_i,
  input  logic [SLOTW-1:0] ins_slot_i,
  input  fpu_wb_t          ins_data_i,
  output fpu_wb_t          head_o,
  output logic [MAXLAT:1]  vld_o
);

  fpu_wb_t res_q   [1:MAXLAT];
  fpu_wb_t res_d   [1:MAXLAT];
  fpu_wb_t shifted [1:MAXLAT];

  // The top slot refills with an empty entry as everything moves down.
  for (genvar k = 1; k <= MAXLAT; k++) begin : g_shift
    if (k < MAXLAT) begin : g_mid
      assign shifted[k] = res_q[k+1];
    end else begin : g_top
      assign shifted[k] = '0;
    end
  end

  always_comb begin
    for (int k = 1; k <= MAXLAT; k++) begin
      res_d[k] = shifted[k];
      if (ins_en_i && (ins_slot_i == SLOTW'(k))) res_d[k] = ins_data_i;
      if (clr_i) res_d[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k <= MAXLAT; k++) res_q[k] <= '0;
    end else begin
      for (int k = 1; k <= MAXLAT; k++) res_q[k] <= res_d[k];
    end
  end

  assign head_o = res_q[1];

  always_comb begin
    vld_o = '0;
    for (int k = 1; k <= MAXLAT; k++) vld_o[k] = res_q[k].valid;
  end

endmodule

// File: rtl/fpu_issue_sched.sv
// rtl/fpu_issue_sched.sv - FPU issue scheduler: accept, fire units, track fdiv, arbitrate writeback
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   scheduler side of fpu_issue_sched_if (issue handshake, flush, unit fire/done,
//         writeback port, illegal-op pulse); all outputs except req_ready are registered
module fpu_issue_sched
  import fpu_issue_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  fpu_issue_sched_if.slave bus
);

  logic            run_q;
  div_state_e      div_state_q;
  logic [TAGW-1:0] div_tag_q;
  logic            hold_vld_q;
  logic [TAGW-1:0] hold_tag_q;
  logic [3:0]      iss_en_q;
  logic            div_start_q;
  logic            err_q;
  fpu_wb_t         wb_q;

  logic             is_fixed;
  logic             is_div;
  logic             is_ill;
  logic             fixed_free;
  logic             ready;
  logic             accept;
  logic [SLOTW-1:0] lat;
  fpu_wb_t          ins_data;
  fpu_wb_t          head;
  logic [MAXLAT:1]  slot_vld;

  always_comb begin
    is_fixed = (bus.req_op < 3'd4);
    is_div   = (bus.req_op == OP_FDIV);
    is_ill   = (bus.req_op > 3'd4);
    lat      = op_lat(bus.req_op);

    // Slot L is free after the shift iff slot L+1 is empty now; the top slot always frees.
    fixed_free = 1'b1;
    for (int k = 1; k < MAXLAT; k++) begin
      if (lat == SLOTW'(k)) fixed_free = !slot_vld[k+1];
    end

    // Illegal ops are consumed even while the hold register blocks real issues.
    ready = run_q && !bus.flush &&
            (is_ill || (!hold_vld_q && (is_fixed ? fixed_free : (div_state_q == DIV_IDLE))));
    accept   = bus.req_valid && ready;
    ins_data = '{valid: 1'b1, tag: bus.req_tag, sel: bus.req_op};
  end

  fpu_issue_sched_wb_slot_pipe u_slots (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (bus.flush),
    .ins_en_i   (accept && is_fixed),
    .ins_slot_i (lat),
    .ins_data_i (ins_data),
    .head_o     (head),
    .vld_o      (slot_vld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q       <= 1'b0;
      div_state_q <= DIV_IDLE;
      div_tag_q   <= '0;
      hold_vld_q  <= 1'b0;
      hold_tag_q  <= '0;
      iss_en_q    <= '0;
      div_start_q <= 1'b0;
      err_q       <= 1'b0;
      wb_q        <= '0;
    end else begin
      run_q       <= 1'b1;
      iss_en_q    <= (accept && is_fixed) ? (4'b0001 << bus.req_op[1:0]) : 4'b0000;
      div_start_q <= accept && is_div;
      err_q       <= accept && is_ill;
      if (accept && is_div) div_tag_q <= bus.req_tag;

      // A divide in flight during a flush stays accounted for (KILL) until its
      // done pulse arrives, so that pulse cannot be mistaken for a later divide.
      case (div_state_q)
        DIV_IDLE: if (accept && is_div) div_state_q <= DIV_BUSY;
        DIV_BUSY: begin
          if (bus.div_done)   div_state_q <= DIV_IDLE;
          else if (bus.flush) div_state_q <= DIV_KILL;
        end
        DIV_KILL: if (bus.div_done) div_state_q <= DIV_IDLE;
        default:  div_state_q <= DIV_IDLE;
      endcase

      // Fixed ops own the port by reservation; the held divide result only takes
      // cycles nobody reserved. A done pulse coinciding with flush is dropped.
      if (bus.flush) begin
        wb_q       <= '0;
        hold_vld_q <= 1'b0;
      end else begin
        if (head.valid) begin
          wb_q <= head;
        end else if (hold_vld_q) begin
          wb_q       <= '{valid: 1'b1, tag: hold_tag_q, sel: OP_FDIV};
          hold_vld_q <= 1'b0;
        end else begin
          wb_q <= '0;
        end
        if ((div_state_q == DIV_BUSY) && bus.div_done) begin
          hold_vld_q <= 1'b1;
          hold_tag_q <= div_tag_q;
        end
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.iss_en      = iss_en_q;
  assign bus.div_start   = div_start_q;
  assign bus.wb_valid    = wb_q.valid;
  assign bus.wb_tag      = wb_q.tag;
  assign bus.wb_sel      = wb_q.sel;
  assign bus.err_illegal = err_q;

endmodule
